pipe_stage_skid: RTL and testbench

Parametrised, elastic pipeline stage register for the pipelined RISC-V core. It is the successor to the fixed EX/MEM latch. It carries a control bundle, a destination-register index and NUM_DATA data words per instruction, using valid/ready handshakes on both sides. A 2-entry skid buffer supports downstream stalls without a combinational ready path, and a synchronous flush inserts bubbles for branch/jump recovery.

---
 rtl/pipe_stage_skid.sv | 134 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer: in_ready is decoded from registered state only,
// so downstream stalls never create a combinational ready path back upstream.
module pipe_stage_skid #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_DATA   = 3,
    parameter int unsigned CTRL_WIDTH = 7,
    parameter int unsigned RD_WIDTH   = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CTRL_WIDTH-1:0]          ctrl_in,
    input  logic [RD_WIDTH-1:0]            rd_in,
    input  logic [NUM_DATA*DATA_WIDTH-1:0] data_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CTRL_WIDTH-1:0]          ctrl_out,
    output logic [RD_WIDTH-1:0]            rd_out,
    output logic [NUM_DATA*DATA_WIDTH-1:0] data_out,
    output logic [1:0]                     occupancy,
    output logic [CNT_WIDTH-1:0]           stall_cnt
);

    localparam int unsigned DW = NUM_DATA * DATA_WIDTH;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e                state_q, state_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [RD_WIDTH-1:0]   main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
    logic [DW-1:0]         main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;
    logic                  in_xfer, out_xfer;

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_rd_d   = main_rd_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_rd_d   = skid_rd_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
            // Main data is left untouched so data_out keeps its last value.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_ctrl_d = ctrl_in;
                        main_rd_d   = rd_in;
                        main_data_d = data_in;
                        state_d     = StOne;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        main_ctrl_d = ctrl_in;
                        main_rd_d   = rd_in;
                        main_data_d = data_in;
                    end else if (in_xfer) begin
                        skid_ctrl_d = ctrl_in;
                        skid_rd_d   = rd_in;
                        skid_data_d = data_in;
                        state_d     = StFull;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_rd_d   = skid_rd_q;
                        main_data_d = skid_data_q;
                        state_d     = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !(&stall_q)) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_rd_q   <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_rd_q   <= '0;
            skid_data_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_rd_q   <= main_rd_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_rd_q   <= skid_rd_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
        end
    end

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StOne:   occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign ctrl_out  = out_valid ? main_ctrl_q : '0;
    assign rd_out    = out_valid ? main_rd_q : '0;
    assign data_out  = main_data_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random valid/ready traffic,
// compared every cycle against a capacity-2 FIFO queue model.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_DATA   = 3;
    localparam int unsigned CTRL_WIDTH = 7;
    localparam int unsigned RD_WIDTH   = 5;
    localparam int unsigned CNT_WIDTH  = 4;
    localparam int unsigned DW         = NUM_DATA * DATA_WIDTH;
    localparam int          CNT_MAX    = (1 << CNT_WIDTH) - 1;

    typedef struct packed {
        logic [CTRL_WIDTH-1:0] ctrl;
        logic [RD_WIDTH-1:0]   rd;
        logic [DW-1:0]         data;
    } ent_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush_i;
    logic                  in_valid;
    logic                  in_ready;
    logic [CTRL_WIDTH-1:0] ctrl_in;
    logic [RD_WIDTH-1:0]   rd_in;
    logic [DW-1:0]         data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [CTRL_WIDTH-1:0] ctrl_out;
    logic [RD_WIDTH-1:0]   rd_out;
    logic [DW-1:0]         data_out;
    logic [1:0]            occupancy;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    pipe_stage_skid #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_DATA  (NUM_DATA),
        .CTRL_WIDTH(CTRL_WIDTH),
        .RD_WIDTH  (RD_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush_i),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ctrl_in  (ctrl_in),
        .rd_in    (rd_in),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ctrl_out (ctrl_out),
        .rd_out   (rd_out),
        .data_out (data_out),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: entries in FIFO order, last head data, saturating stall count.
    ent_t          mq[$];
    logic [DW-1:0] m_last;
    int            m_stall;
    int            n_assert = 0;
    int            n_fail   = 0;
    int            n_out    = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last  = '0;
        m_stall = 0;
    endtask

    task automatic check_now();
        ent_t h;
        logic ev;
        logic rsave;
        ev = (mq.size() > 0);
        h  = ev ? mq[0] : '0;
        chk("out_valid", out_valid, ev);
        chk("in_ready", in_ready, mq.size() < 2);
        chk("ctrl_out", ctrl_out, ev ? h.ctrl : '0);
        chk("rd_out", rd_out, ev ? h.rd : '0);
        chk("data_out", data_out, ev ? h.data : m_last);
        chk("occupancy", occupancy, mq.size());
        chk("stall_cnt", stall_cnt, m_stall);
        // in_ready must not move when out_ready does.
        rsave     = out_ready;
        out_ready = ~rsave;
        #1;
        chk("in_ready_vs_out_ready", in_ready, mq.size() < 2);
        out_ready = rsave;
        #1;
    endtask

    // Check at the falling edge, advance the model with the inputs seen at the rising edge.
    task automatic tick();
        ent_t e;
        logic ov;
        logic ir;
        @(negedge clk);
        check_now();
        ov = (mq.size() > 0);
        ir = (mq.size() < 2);
        if (ov && !out_ready && m_stall < CNT_MAX) m_stall++;
        if (flush_i) begin
            mq.delete();
        end else begin
            if (ov && out_ready) begin
                void'(mq.pop_front());
                n_out++;
            end
            if (in_valid && ir) begin
                e.ctrl = ctrl_in;
                e.rd   = rd_in;
                e.data = data_in;
                mq.push_back(e);
            end
        end
        if (mq.size() > 0) m_last = mq[0].data;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [RD_WIDTH-1:0] rd, input logic [31:0] ch0,
                         input logic ordy, input logic fl);
        in_valid  = v;
        rd_in     = rd;
        ctrl_in   = CTRL_WIDTH'($urandom);
        data_in   = {32'($urandom), 32'($urandom), ch0};
        out_ready = ordy;
        flush_i   = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_now();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming at one entry per cycle.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, RD_WIDTH'(i), 32'h10 + 32'(i - 1), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) tick();

        // Backpressure: fill both slots, hold a third entry off, then drain in order.
        for (int i = 5; i <= 7; i++) begin
            drive(1'b1, RD_WIDTH'(i), 32'h20 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 5'd7, 32'h27, 1'b0, 1'b0);
        repeat (2) tick();
        drive(1'b1, 5'd7, 32'h27, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (4) tick();

        // Flush while full, with a discarded entry on the input.
        drive(1'b1, 5'd8, 32'h28, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd9, 32'h29, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd10, 32'h2a, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) tick();

        // Stall counter saturation.
        drive(1'b1, 5'd11, 32'h2b, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (20) tick();
        chk("stall_saturated", stall_cnt, CNT_MAX);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (2) tick();

        // Asynchronous reset between edges while full; inputs ignored in reset.
        drive(1'b1, 5'd12, 32'h2c, 1'b0, 1'b0);
        repeat (2) tick();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_now();
        drive(1'b1, 5'd13, 32'h2d, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_now();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 5'd14, 32'h2e, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        chk("post_reset_delivered", rd_out, 5'd0);

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(0, 99) < 70, RD_WIDTH'($urandom), 32'($urandom),
                  $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 2);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) tick();
        chk("drained", occupancy, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
